// File: rtl/mem_access_stage.sv
// MEM-stage data-memory access engine: EX/MEM load/store -> req/ack memory transaction -> readDataM to MEM/WB.
// Latency: stall of 2 cycles minimum (IDLE + first BUSY cycle), plus 1 per ack wait; readDataM valid in the DONE cycle.
// Backpressure: stallM holds the upstream pipeline while the request is outstanding; MEM_TIMEOUT_EN enables a BUSY watchdog.
module mem_access_stage #(
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memRead_in,
  input  logic              memWrite_in,
  input  logic              flush_in,
  input  logic [ADDR_W-1:0] aluRes_in,
  input  logic [DATA_W-1:0] writeData_in,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ack,
  output logic [DATA_W-1:0] readDataM,
  output logic              stallM,
  output logic              misalign_err,
  output logic              timeout_err
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t            r_state;
  state_t            w_next;
  logic              w_acc;
  logic              w_issue;
  logic              w_misalign;
  logic              w_ack_done;
  logic              w_timeout;
  logic              w_stall;
  logic              r_req;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_misalign;
  logic              r_timeout;

  // A flushed instruction never reaches memory; odd addresses are rejected without a request.
  assign w_acc      = (memRead_in | memWrite_in) & ~flush_in;
  assign w_issue    = (r_state == S_IDLE) & w_acc & ~aluRes_in[0];
  assign w_misalign = (r_state == S_IDLE) & w_acc &  aluRes_in[0];
  assign w_ack_done = (r_state == S_BUSY) & dmem_ack;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_cnt;

  // Count BUSY cycles; cleared when a request is issued so each access gets a full budget.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (w_issue) begin
      r_cnt <= '0;
    end else if (r_state == S_BUSY) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Fires on the last allowed BUSY cycle; an ack in that same cycle wins.
  assign w_timeout = (r_state == S_BUSY) & ~dmem_ack & (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  // Without the watchdog BUSY waits for ack indefinitely.
  assign w_timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state and stall: stall covers the issuing IDLE cycle and all BUSY cycles; DONE releases the pipeline.
  always_comb begin
    w_next  = r_state;
    w_stall = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_issue) begin
          w_stall = 1'b1;
          w_next  = S_BUSY;
        end
      end
      S_BUSY: begin
        w_stall = 1'b1;
        if (w_ack_done || w_timeout) w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Memory port, load result and error pulses; request fields stay frozen from issue until completion.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_req      <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_misalign <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_misalign <= w_misalign;
      r_timeout  <= w_timeout;
      if (w_issue) begin
        r_req   <= 1'b1;
        r_we    <= memWrite_in;
        r_addr  <= aluRes_in;
        r_wdata <= writeData_in;
      end else if (w_ack_done || w_timeout) begin
        r_req <= 1'b0;
      end
      if (w_ack_done && !r_we) begin
        r_rdata <= dmem_rdata;
      end else if (w_timeout && !r_we) begin
        r_rdata <= DATA_W'(16'hDEAD);
      end
    end
  end

  assign dmem_req     = r_req;
  assign dmem_we      = r_we;
  assign dmem_addr    = r_addr;
  assign dmem_wdata   = r_wdata;
  assign readDataM    = r_rdata;
  assign stallM       = w_stall;
  assign misalign_err = r_misalign;
  assign timeout_err  = r_timeout;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed scenarios then randomized accesses against a transaction-level model.
// Inputs are driven on the falling edge; outputs are sampled 1 time unit later.
// The model tracks only the last loaded word and the expected stall length of each access.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        memRead_in, memWrite_in, flush_in;
  logic [15:0] aluRes_in, writeData_in;
  logic        dmem_req, dmem_we;
  logic [15:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_ack;
  logic [15:0] readDataM;
  logic        stallM, misalign_err, timeout_err;

  int checks   = 0;
  int failures = 0;
  logic [15:0] exp_rdm;

  always #5 clk = ~clk;

  mem_access_stage #(.ADDR_W(16), .DATA_W(16), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .memRead_in(memRead_in), .memWrite_in(memWrite_in), .flush_in(flush_in),
    .aluRes_in(aluRes_in), .writeData_in(writeData_in),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .readDataM(readDataM), .stallM(stallM),
    .misalign_err(misalign_err), .timeout_err(timeout_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    memRead_in = 1'b0; memWrite_in = 1'b0; flush_in = 1'b0;
    aluRes_in = 16'h0; writeData_in = 16'h0;
  endtask

  // One pipeline instruction in MEM. waits = ack wait cycles after the first BUSY cycle.
  task automatic access(input bit rd, input bit wr, input bit fl, input logic [15:0] addr,
                        input logic [15:0] wd, input logic [15:0] rdv, input int waits);
    bit valid, mis;
    int stalls;
    valid  = (rd || wr) && !fl && !addr[0];
    mis    = (rd || wr) && !fl &&  addr[0];
    stalls = 0;
    @(negedge clk);
    memRead_in = rd; memWrite_in = wr; flush_in = fl;
    aluRes_in = addr; writeData_in = wd; dmem_ack = 1'b0;
    #1;
    chk("idle_stall", stallM, valid);
    chk("idle_req", dmem_req, 0);
    chk("idle_rdm", readDataM, exp_rdm);
    if (stallM) stalls++;
    @(posedge clk);
    if (valid) begin
      for (int w = 0; w <= waits; w++) begin
        @(negedge clk);
        dmem_ack   = (w == waits);
        dmem_rdata = (w == waits) ? rdv : 16'($urandom);
        #1;
        chk("busy_req", dmem_req, 1);
        chk("busy_we", dmem_we, wr);
        chk("busy_addr", dmem_addr, addr);
        chk("busy_wdata", dmem_wdata, wd);
        if (stallM) stalls++;
        @(posedge clk);
      end
      @(negedge clk);
      dmem_ack = 1'b0; dmem_rdata = 16'($urandom);
      if (rd && !wr) exp_rdm = rdv;
      #1;
      chk("done_stall", stallM, 0);
      chk("done_req", dmem_req, 0);
      chk("done_rdm", readDataM, exp_rdm);
      chk("done_timeout", timeout_err, 0);
      chk("stall_count", stalls, waits + 2);
      @(posedge clk);
    end else begin
      @(negedge clk);
      clear_inputs();
      #1;
      chk("err_pulse", misalign_err, mis);
      chk("noacc_req", dmem_req, 0);
      chk("noacc_rdm", readDataM, exp_rdm);
      @(posedge clk);
      @(negedge clk);
      #1;
      chk("err_clear", misalign_err, 0);
    end
  endtask

  initial begin
    reset = 1'b0; clear_inputs(); dmem_ack = 1'b0; dmem_rdata = 16'h0; exp_rdm = 16'h0;
    #12;
    chk("rst_req", dmem_req, 0);
    chk("rst_we", dmem_we, 0);
    chk("rst_addr", dmem_addr, 0);
    chk("rst_wdata", dmem_wdata, 0);
    chk("rst_rdm", readDataM, 0);
    chk("rst_merr", misalign_err, 0);
    chk("rst_terr", timeout_err, 0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk);

    // Load with immediate ack, then store with 3 ack waits (readDataM must hold).
    access(1, 0, 0, 16'h0010, 16'h0000, 16'h1234, 0);
    access(0, 1, 0, 16'h0020, 16'hBEEF, 16'h5555, 3);
    // Read+write together behaves as a store.
    access(1, 1, 0, 16'h0022, 16'hCAFE, 16'h7777, 1);
    // Misaligned load, flushed load.
    access(1, 0, 0, 16'h0011, 16'h0000, 16'h9999, 0);
    access(1, 0, 1, 16'h0012, 16'h0000, 16'h9999, 0);
    // Back-to-back loads.
    access(1, 0, 0, 16'h0002, 16'h0000, 16'hA1A1, 0);
    access(1, 0, 0, 16'h0004, 16'h0000, 16'hB2B2, 0);

    // Stray ack while idle is ignored.
    @(negedge clk); clear_inputs(); dmem_ack = 1'b1; dmem_rdata = 16'hFFFF;
    #1; chk("stray_stall", stallM, 0);
    @(negedge clk); dmem_ack = 1'b0;
    #1;
    chk("stray_req", dmem_req, 0);
    chk("stray_rdm", readDataM, exp_rdm);
    chk("stray_stall2", stallM, 0);

    // Asynchronous reset while BUSY.
    @(negedge clk); memRead_in = 1'b1; aluRes_in = 16'h0040;
    @(negedge clk); #1;
    chk("pre_rst_req", dmem_req, 1);
    #1; reset = 1'b0; clear_inputs();
    #1;
    exp_rdm = 16'h0;
    chk("arst_req", dmem_req, 0);
    chk("arst_rdm", readDataM, 0);
    chk("arst_stall", stallM, 0);
    @(negedge clk); reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("post_rst_req", dmem_req, 0);
    end

    // Randomized instruction stream.
    for (int n = 0; n < 60; n++) begin
      int kind;
      logic [15:0] a;
      kind = $urandom_range(0, 5);
      a = 16'($urandom) & 16'hFFFE;
      case (kind)
        0: access(0, 0, 0, a, 16'($urandom), 16'($urandom), 0);
        1: access(1, 0, 0, a, 16'($urandom), 16'($urandom), $urandom_range(0, 4));
        2: access(0, 1, 0, a, 16'($urandom), 16'($urandom), $urandom_range(0, 4));
        3: access(1, 1, 0, a, 16'($urandom), 16'($urandom), $urandom_range(0, 4));
        4: access(1, $urandom_range(0, 1), 1, a, 16'($urandom), 16'($urandom), 0);
        default: access($urandom_range(0, 1), 1'b1, 0, a | 16'h1, 16'($urandom), 16'($urandom), 0);
      endcase
    end

`ifdef MEM_TIMEOUT_EN
    // Load with no ack: request held for 4 BUSY cycles, then abort with 0xDEAD.
    @(negedge clk); memRead_in = 1'b1; aluRes_in = 16'h0030; dmem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      chk("to_busy_req", dmem_req, 1);
      chk("to_busy_stall", stallM, 1);
    end
    @(negedge clk); #1;
    exp_rdm = 16'hDEAD;
    chk("to_req", dmem_req, 0);
    chk("to_err", timeout_err, 1);
    chk("to_rdm", readDataM, exp_rdm);
    chk("to_stall", stallM, 0);
    clear_inputs();
    @(negedge clk); #1;
    chk("to_err_clear", timeout_err, 0);
    chk("to_req_after", dmem_req, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM-stage data-memory access engine between the EX/MEM pipeline register and the MEM/WB pipeline register.
- Turns load/store control from EX/MEM into a req/ack transaction on the data-memory port.
- Stalls the pipeline until the transaction completes, then presents the loaded word (readDataM) to MEM/WB.
- Datapath is 16-bit, byte-addressed, word accesses only.

Parameters:
- ADDR_W, 16, data-memory address width.
- DATA_W, 16, data word width.
- TIMEOUT_CYCLES, 64, maximum BUSY cycles before abort (only with MEM_TIMEOUT_EN).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- memRead_in  input  1  load request from EX/MEM.
- memWrite_in  input  1  store request from EX/MEM.
- flush_in  input  1  squash the current MEM-stage instruction.
- aluRes_in  input  ADDR_W  effective address.
- writeData_in  input  DATA_W  store data.
- dmem_req  output  1  memory request, registered.
- dmem_we  output  1  1 = write, 0 = read, registered.
- dmem_addr  output  ADDR_W  request address, registered.
- dmem_wdata  output  DATA_W  store data, registered.
- dmem_rdata  input  DATA_W  read data; valid when dmem_ack=1.
- dmem_ack  input  1  one-cycle completion pulse from memory.
- readDataM  output  DATA_W  last loaded word, registered, feeds MEM/WB.
- stallM  output  1  holds IF/ID/EX/EX-MEM, combinational.
- misalign_err  output  1  one-cycle pulse, registered.
- timeout_err  output  1  one-cycle pulse, registered.

Behaviour:
- Reset (reset=0), applied immediately regardless of clock:
  - FSM goes to IDLE.
  - dmem_req, dmem_we, misalign_err, timeout_err = 0.
  - dmem_addr, dmem_wdata, readDataM = 0.
- FSM states: IDLE, BUSY, DONE.
- acc = (memRead_in | memWrite_in) & ~flush_in.
- IDLE, acc=1, aluRes_in[0]=0:
  - stallM=1 this cycle.
  - Next edge: dmem_req<=1; dmem_we<=memWrite_in; dmem_addr<=aluRes_in; dmem_wdata<=writeData_in; go to BUSY.
- IDLE, acc=1, aluRes_in[0]=1 (misaligned):
  - No request issued; stallM=0.
  - misalign_err pulses 1 the next cycle; readDataM unchanged; stay in IDLE.
- IDLE, acc=0: stallM=0; stay in IDLE.
- Read and write both high: treated as a store (write priority).
- BUSY:
  - stallM=1.
  - dmem_req, dmem_we, dmem_addr and dmem_wdata held stable until ack.
  - On dmem_ack=1: dmem_req<=0; for a read, readDataM<=dmem_rdata; go to DONE.
- DONE:
  - stallM=0, so the pipeline advances at this edge and the held instruction is consumed.
  - Inputs ignored (no reissue); go to IDLE.
- Latency:
  - Minimum stall is 2 cycles (IDLE + one BUSY with immediate ack); each extra ack wait adds 1 cycle.
  - readDataM is valid in the DONE cycle.
- readDataM changes only on load completion; it holds across stores and non-memory instructions.
- dmem_ack seen in IDLE or DONE is ignored.
- flush_in suppresses issue in IDLE only. In BUSY, flush is ignored: a request is never withdrawn before ack (bus rule).
- Back-to-back accesses: the next access is accepted in the IDLE cycle after DONE; there is 1 idle cycle between requests.
- Reset mid-BUSY: dmem_req drops asynchronously. The memory must tolerate the abandoned request; readDataM returns to 0.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - A BUSY-cycle counter clears on entry to BUSY.
  - If the counter reaches TIMEOUT_CYCLES with no ack: dmem_req<=0, readDataM<=16'hDEAD (loads only), timeout_err pulses 1 for 1 cycle, go to DONE.
  - An ack arriving in the same cycle as the timeout takes priority (normal completion, no error).
- Undefined:
  - No counter; BUSY waits indefinitely.
  - timeout_err tied to 0.

Test Plan:
- Reset: reset=0 mid-BUSY -> dmem_req=0 immediately, readDataM=0, state IDLE; after release, no spurious request.
- Load, ack on first BUSY cycle: memRead_in=1, addr 0x0010, dmem_rdata=0x1234 -> stallM=1 for 2 cycles; dmem_req=1 with dmem_we=0, addr 0x0010; readDataM=0x1234 in DONE with stallM=0.
- Store, ack after 3 waits: memWrite_in=1, addr 0x0020, data 0xBEEF -> dmem_we=1, wdata 0xBEEF held stable 4 cycles; stallM=1 for 5 cycles; readDataM unchanged.
- Misaligned/flush: load at addr 0x0011 -> no dmem_req, misalign_err=1 for one cycle, stallM=0. Load with flush_in=1 -> no request, no error.
- Back-to-back loads 0x0002 then 0x0004 with immediate acks -> two distinct requests separated by 1 idle cycle; readDataM updated in order; stray ack in IDLE ignored.
- MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> dmem_req drops after 4 BUSY cycles, timeout_err=1 once, readDataM=0xDEAD, pipeline resumes.
